// File: rtl/seq_bit_serializer_pkg.sv
// seq_pkg: definitions shared by the bit serializer and the sequence-detector bench.
//   state_t          - shifter state (S_IDLE: no bits left, S_SHIFT: bits pending)
//   DEFAULT_WIDTH    - default parallel word width
//   DEFAULT_IDLE_BIT - default serial line level when no word is being shifted
//   norm_len()       - maps a raw length field to the number of bits actually sent
package seq_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b1;

  // A zero length, or one longer than the word, means "send the whole word".
  function automatic int norm_len(input int len, input int width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/seq_bit_serializer_hold_reg.sv
// seq_hold_reg: one-entry holding register that queues a word behind the shifter.
//   clk, rst_n      - clock, asynchronous active-low reset
//   push            - store push_data/push_len this edge (caller guarantees ready)
//   push_data/len   - word and its already-normalised length
//   drain           - the shifter takes the held word this edge
//   full            - a word is held
//   ready           - a new word may be pushed (combinational from full)
//   data/len        - the held word and length
module seq_hold_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [LENW-1:0]  push_len,
  input  logic             drain,
  output logic             full,
  output logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [LENW-1:0]  len
);

  logic             full_reg, full_next;
  logic [WIDTH-1:0] data_reg;
  logic [LENW-1:0]  len_reg;

  // A push on the same edge as a drain leaves the register full with the new word.
  always_comb begin
    full_next = full_reg;
    if (push) begin
      full_next = 1'b1;
    end else if (drain) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
      len_reg  <= '0;
    end else begin
      full_reg <= full_next;
      if (push) begin
        data_reg <= push_data;
        len_reg  <= push_len;
      end
    end
  end

  assign full  = full_reg;
  assign ready = !full_reg;
  assign data  = data_reg;
  assign len   = len_reg;

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial feeder for the sequence detector.
// Words are accepted on a valid/ready handshake and shifted out MSB-first,
// one bit per clock, with a one-word holding register for gapless streaming.
//   CLK        - clock, rising edge
//   RESET      - asynchronous active-low reset
//   LOAD_VALID - a word is offered
//   LOAD_READY - a word can be accepted this cycle
//   LOAD_DATA  - word to send, first bit is LOAD_DATA[WIDTH-1]
//   LOAD_LEN   - bits to send; 0 or > WIDTH means WIDTH
//   DOUT       - registered serial bit
//   DOUT_VALID - DOUT carries a data bit
//   BUSY       - shifter, holding register or output stage occupied
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH    = DEFAULT_WIDTH,
  parameter int   LENW     = $clog2(WIDTH + 1),
  parameter logic IDLE_BIT = DEFAULT_IDLE_BIT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic [LENW-1:0]  LOAD_LEN,
  output logic             DOUT,
  output logic             DOUT_VALID,
  output logic             BUSY
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [LENW-1:0]  cnt_reg, cnt_next;
  logic             dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;

  logic             hold_full, hold_ready;
  logic [WIDTH-1:0] hold_data;
  logic [LENW-1:0]  hold_len;
  logic             hold_push, hold_drain;

  logic             accept;
  logic             last_bit;
  logic             to_shifter;
  logic [LENW-1:0]  load_len_norm;

  assign accept        = LOAD_VALID && hold_ready;
  assign load_len_norm = LENW'(norm_len(int'(LOAD_LEN), WIDTH));
  assign last_bit      = (state_reg == S_SHIFT) && (cnt_reg == LENW'(1));

  // A new word bypasses the holding register whenever the shifter will be
  // free on this edge and nothing is already queued ahead of it.
  assign to_shifter = (state_reg == S_IDLE) || (last_bit && !hold_full);
  assign hold_drain = last_bit && hold_full;
  assign hold_push  = accept && !to_shifter;

  seq_hold_reg #(
    .WIDTH(WIDTH),
    .LENW (LENW)
  ) u_hold (
    .clk      (CLK),
    .rst_n    (RESET),
    .push     (hold_push),
    .push_data(LOAD_DATA),
    .push_len (load_len_norm),
    .drain    (hold_drain),
    .full     (hold_full),
    .ready    (hold_ready),
    .data     (hold_data),
    .len      (hold_len)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= S_IDLE;
      sh_reg         <= '0;
      cnt_reg        <= '0;
      dout_reg       <= IDLE_BIT;
      dout_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sh_reg         <= sh_next;
      cnt_reg        <= cnt_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
    end
  end

  // Next-state logic: shift/count datapath and reload from input or holding register
  always_comb begin
    sh_next  = sh_reg;
    cnt_next = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          sh_next  = LOAD_DATA;
          cnt_next = load_len_norm;
        end
      end
      S_SHIFT: begin
        sh_next  = sh_reg << 1;
        cnt_next = cnt_reg - LENW'(1);
        // On the last bit the shifter is reloaded so the next word's MSB
        // follows immediately with no idle bit.
        if (hold_drain) begin
          sh_next  = hold_data;
          cnt_next = hold_len;
        end else if (accept && to_shifter) begin
          sh_next  = LOAD_DATA;
          cnt_next = load_len_norm;
        end
      end
      default: begin
        sh_next  = sh_reg;
        cnt_next = cnt_reg;
      end
    endcase
    state_next = (cnt_next != '0) ? S_SHIFT : S_IDLE;
  end

  // Output logic: the serial stage is registered, so it reflects the current state
  always_comb begin
    dout_next       = IDLE_BIT;
    dout_valid_next = 1'b0;
    if (state_reg == S_SHIFT) begin
      dout_next       = sh_reg[WIDTH-1];
      dout_valid_next = 1'b1;
    end
  end

  assign DOUT       = dout_reg;
  assign DOUT_VALID = dout_valid_reg;
  assign LOAD_READY = hold_ready;
  assign BUSY       = (cnt_reg != '0) || hold_full || dout_valid_reg;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: the driver pushes the expected bit stream of
// every accepted word into a scoreboard queue; a monitor on the falling edge
// derives the expected serial outputs, ready and busy from that queue.
module tb_seq_bit_serializer;
  import seq_pkg::*;

  localparam int W = 8;
  localparam int LW = $clog2(W + 1);

  logic          CLK;
  logic          RESET;
  logic          LOAD_VALID;
  logic          LOAD_READY;
  logic [W-1:0]  LOAD_DATA;
  logic [LW-1:0] LOAD_LEN;
  logic          DOUT;
  logic          DOUT_VALID;
  logic          BUSY;

  seq_bit_serializer #(.WIDTH(W), .LENW(LW), .IDLE_BIT(1'b1)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(LOAD_READY),
    .LOAD_DATA (LOAD_DATA),
    .LOAD_LEN  (LOAD_LEN),
    .DOUT      (DOUT),
    .DOUT_VALID(DOUT_VALID),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic b;
    int   word_id;
    int   acc_edge;
  } exp_bit_t;

  exp_bit_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int word_cnt = 0;

  always @(posedge CLK) edge_cnt++;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: a word accepted at edge k shows its first bit after edge k+1 and
  // bits then flow one per clock. The block holds at most two unsent words.
  always @(negedge CLK) begin
    logic exp_v, exp_d, exp_busy, exp_rdy;
    int words, last_id, first;
    if (RESET) begin
      exp_busy = (sb.size() > 0);
      exp_v    = (sb.size() > 0) && (sb[0].acc_edge < edge_cnt);
      exp_d    = exp_v ? sb[0].b : 1'b1;
      first    = exp_v ? 1 : 0;
      words    = 0;
      last_id  = -1;
      for (int i = first; i < sb.size(); i++) begin
        if (sb[i].word_id != last_id) begin
          words++;
          last_id = sb[i].word_id;
        end
      end
      exp_rdy = (words < 2);
      chk("dout_valid", DOUT_VALID, exp_v);
      chk("dout", DOUT, exp_d);
      chk("busy", BUSY, exp_busy);
      chk("load_ready", LOAD_READY, exp_rdy);
      if (exp_v) void'(sb.pop_front());
    end
  end

  // Called at a drive point (just after a falling edge). Holds LOAD_VALID
  // until accepted, leaves it high, returns at the next drive point.
  task automatic offer(input logic [W-1:0] d, input logic [LW-1:0] l);
    int waited = 0;
    int n;
    LOAD_VALID = 1'b1;
    LOAD_DATA  = d;
    LOAD_LEN   = l;
    while (!LOAD_READY && waited < 100) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    if (!LOAD_READY) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: load_ready stuck at %b, required 1", LOAD_READY);
    end else begin
      n = ((l == 0) || (l > W)) ? W : int'(l);
      for (int i = 0; i < n; i++) begin
        exp_bit_t e;
        e.b        = d[W-1-i];
        e.word_id  = word_cnt;
        e.acc_edge = edge_cnt + 1;
        sb.push_back(e);
      end
      $display("word %0d: data=%h len=%0d -> %0d bits", word_cnt, d, l, n);
      word_cnt++;
    end
    @(negedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    LOAD_VALID = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_dout", DOUT, 1'b1);
    chk("rst_dout_valid", DOUT_VALID, 1'b0);
    chk("rst_load_ready", LOAD_READY, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic reset_mid();
    LOAD_VALID = 1'b0;
    #2;
    RESET = 1'b0;
    #1;
    chk_reset_outputs();
    sb.delete();
    @(negedge CLK);
    #1;
    chk_reset_outputs();
    RESET = 1'b1;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    RESET      = 1'b0;
    LOAD_VALID = 1'b0;
    LOAD_DATA  = '0;
    LOAD_LEN   = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outputs();
    #2;
    RESET = 1'b1;
    @(negedge CLK);
    #1;

    // First accept on the very first edge after release, then directed words.
    offer(8'b0101_1101, 4'd8);
    idle(12);
    idle(5);
    offer(8'b1010_0000, 4'd3);
    idle(6);
    offer(8'hC3, 4'd0);
    idle(10);
    offer(8'h96, 4'd12);
    idle(10);

    // Three back-to-back words with LOAD_VALID held: 24 contiguous bits.
    offer(8'hA5, 4'd8);
    offer(8'h3C, 4'd8);
    offer(8'hF0, 4'd8);
    idle(30);

    // Accept exactly on the last-bit edge with the holding register empty.
    offer(8'hC0, 4'd2);
    idle(1);
    offer(8'h80, 4'd1);
    offer(8'h40, 4'd2);
    idle(6);

    // Short words streaming through a full holding register.
    offer(8'hE0, 4'd2);
    offer(8'h60, 4'd3);
    offer(8'hA0, 4'd2);
    offer(8'h50, 4'd4);
    idle(15);

    // Reset at bit 4 of a word with a second word held.
    offer(8'h5A, 4'd8);
    offer(8'hFF, 4'd8);
    idle(3);
    reset_mid();
    idle(15);

    // Randomized words, lengths and gaps.
    for (int k = 0; k < 150; k++) begin
      offer(W'($urandom), LW'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(40);

    // Random reset while busy, then confirm the stream recovers.
    offer(W'($urandom), 4'd8);
    offer(W'($urandom), 4'd8);
    idle($urandom_range(0, 6));
    reset_mid();
    idle(10);
    for (int k = 0; k < 20; k++) offer(W'($urandom), LW'($urandom_range(0, 15)));
    idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
